// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: shares the single tank between sprinkler and drip,
// sequences refills through the inlet valve and latches a refill-timeout fault.
module irrigation_scheduler #(
    parameter int SLOT_LEN     = 8,
    parameter int DEAD_LEN     = 2,
    parameter int FILL_TIMEOUT = 16,
    parameter int LOW_LVL      = 1,
    parameter int FULL_LVL     = 7,
    parameter int ADB_MIN_LVL  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_asp,
    input  logic       req_got,
    input  logic       req_adb,
    input  logic [2:0] nivel,
    input  logic       limp_busy,
    output logic       grant_asp,
    output logic       grant_got,
    output logic       VE,
    output logic       adb_en,
    output logic       erro,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        RUN_ASP = 3'd2,
        RUN_GOT = 3'd3,
        DEAD    = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [4:0] SLOT_END = 5'(SLOT_LEN - 1);
    localparam logic [4:0] DEAD_END = 5'(DEAD_LEN - 1);
    localparam logic [4:0] FILL_END = 5'(FILL_TIMEOUT - 1);
    localparam logic [4:0] TMR_MAX  = 5'h1f;
    localparam logic [2:0] LOW      = 3'(LOW_LVL);
    localparam logic [2:0] FULL     = 3'(FULL_LVL);
    localparam logic [2:0] ADB_MIN  = 3'(ADB_MIN_LVL);

    state_t     state;
    state_t     state_n;
    logic [4:0] timer;
    logic       last_got;
    logic       is_run;
    logic       own_req;
    logic       other_req;
    logic       slot_end;
    logic       grant_asp_n;
    logic       grant_got_n;
    logic       ve_n;
    logic       adb_en_n;
    logic       erro_n;

    assign is_run    = (state == RUN_ASP) || (state == RUN_GOT);
    assign own_req   = (state == RUN_ASP) ? req_asp : req_got;
    assign other_req = (state == RUN_ASP) ? req_got : req_asp;
    assign slot_end  = (timer == SLOT_END);
    assign estado    = state;

    // state register, timer, round-robin memory and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            last_got  <= 1'b1;
            grant_asp <= 1'b0;
            grant_got <= 1'b0;
            VE        <= 1'b0;
            adb_en    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            state     <= state_n;
            grant_asp <= grant_asp_n;
            grant_got <= grant_got_n;
            VE        <= ve_n;
            adb_en    <= adb_en_n;
            erro      <= erro_n;
            if (state_n != state) begin
                timer <= '0;
            end else if (is_run && slot_end) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 5'd1;
            end
            if (state == IDLE && state_n == RUN_ASP) begin
                last_got <= 1'b0;
            end else if (state == IDLE && state_n == RUN_GOT) begin
                last_got <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (nivel < LOW) begin
                    state_n = FILL;
                end else if (limp_busy) begin
                    state_n = IDLE;
                end else if (req_asp && req_got) begin
                    state_n = last_got ? RUN_ASP : RUN_GOT;
                end else if (req_asp) begin
                    state_n = RUN_ASP;
                end else if (req_got) begin
                    state_n = RUN_GOT;
                end
            end
            FILL: begin
                if (nivel >= FULL) begin
                    state_n = DEAD;
                end else if (timer == FILL_END) begin
                    state_n = FAULT;
                end
            end
            RUN_ASP, RUN_GOT: begin
                if (nivel == 3'd0 || limp_busy || !own_req) begin
                    state_n = DEAD;
                end else if (slot_end && other_req) begin
                    state_n = DEAD;
                end
            end
            DEAD: begin
                if (timer == DEAD_END) begin
                    state_n = IDLE;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    // outputs are decoded from the upcoming state so they register with it
    always_comb begin
        grant_asp_n = (state_n == RUN_ASP);
        grant_got_n = (state_n == RUN_GOT);
        ve_n        = (state_n == FILL);
        erro_n      = (state_n == FAULT);
        adb_en_n    = (state_n == RUN_ASP) && req_adb && (nivel >= ADB_MIN);
    end

endmodule
